// File: rtl/fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding I-bus requests, drives the F->D register.
// Latency: iresp_data_ok in cycle N makes dataF valid in N+1; up to 1 instruction/cycle.
// Backpressure: stall holds dataF and parks a returned word in a skid buffer; redirect beats stall.
// Optional perf counters (perf_fetched, perf_bubble) under `FETCH_PERF_CNT_EN.
package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;
endpackage

module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output fetch_data_t dataF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_bubble
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_addr;
    logic [31:0] skid_buf;

    logic [63:0] redir_tgt;
    logic [63:0] pc_inc;
    logic        load_valid;

    assign redir_tgt  = redirect_pc & ~64'd3;
    assign pc_inc     = pc + 64'd4;
    assign ireq_valid = ~reset & (state != S_HOLD);
    assign ireq_addr  = req_addr;

    // A valid instruction enters dataF this cycle.
    always_comb begin
        load_valid = 1'b0;
        if (!redirect_valid) begin
            case (state)
                S_REQ:   load_valid = iresp_data_ok & ~stall;
                S_HOLD:  load_valid = ~stall;
                default: load_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= PC_RESET;
            req_addr <= PC_RESET;
            skid_buf <= '0;
            dataF    <= '0;
        end else begin
            if (redirect_valid) begin
                dataF.valid <= 1'b0;
            end else if (load_valid) begin
                dataF <= '{valid: 1'b1, pc: pc,
                           raw_instr: (state == S_HOLD) ? skid_buf : iresp_data};
            end else if (!stall) begin
                dataF.valid <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                        // An unanswered request cannot be withdrawn; wait it out in DROP.
                        if (iresp_data_ok) req_addr <= redir_tgt;
                        else               state    <= S_DROP;
                    end else if (iresp_data_ok) begin
                        if (stall) begin
                            skid_buf <= iresp_data;
                            state    <= S_HOLD;
                        end else begin
                            pc       <= pc_inc;
                            req_addr <= pc_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc       <= redir_tgt;
                        req_addr <= redir_tgt;
                        state    <= S_REQ;
                    end else if (!stall) begin
                        pc       <= pc_inc;
                        req_addr <= pc_inc;
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) pc <= redir_tgt;
                    // Stale word arrives: discard it and request the latest target.
                    if (iresp_data_ok) begin
                        req_addr <= redirect_valid ? redir_tgt : pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if (load_valid)                  perf_fetched <= perf_fetched + 64'd1;
            if (ireq_valid && !iresp_data_ok) perf_bubble <= perf_bubble + 64'd1;
        end
    end
`endif

endmodule
